muntjac_clint: RTL and testbench

- Core-local interruptor that generates the machine timer and software interrupt requests the Muntjac core receives as irq_timer_m and irq_software_m.
- Holds a free-running 64-bit mtime counter, one mtimecmp and one msip register per hart, all accessible over a single-outstanding register request/response bus.
- Sits next to the core complex on the MMIO fabric.

---
 rtl/muntjac_clint.sv | 195 +++++++++++++++++++
 tb/tb_muntjac_clint.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muntjac_clint.sv
// Core-local interruptor: free-running mtime, per-hart mtimecmp/msip, single-outstanding register bus.
// Define MUNTJAC_CLINT_PRESCALE_EN to advance mtime only once every TickDiv cycles.
module muntjac_clint #(
  parameter int unsigned NumHarts  = 1,
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned TickDiv   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [63:0]          req_wdata_i,
  input  logic [7:0]           req_wmask_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [63:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [63:0]          mtime_o,
  output logic [NumHarts-1:0]  irq_software_m_o,
  output logic [NumHarts-1:0]  irq_timer_m_o
);

  // state   | meaning
  // ST_IDLE | no response outstanding, request port ready
  // ST_RESP | response presented; next request accepted as this one is consumed

  localparam int unsigned PairCount = (NumHarts + 1) / 2;
  localparam int unsigned WordWidth = AddrWidth - 3;
  localparam logic [WordWidth-1:0] MtimeWord = WordWidth'(32'h17FF);
  localparam logic [WordWidth-1:0] CmpWord   = WordWidth'(32'h0800);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   accept;

  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         mtimecmp_q [NumHarts];
  logic [63:0]         mtimecmp_d [NumHarts];
  logic [NumHarts-1:0] msip_q, msip_d;
  logic [NumHarts-1:0] irq_timer_q, irq_timer_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                error_q, error_d;

  logic [WordWidth-1:0] word;
  logic                 unused_addr_lsbs;
  logic                 hit_mtime;
  logic [NumHarts-1:0]  hit_cmp;
  logic [PairCount-1:0] hit_pair;
  logic                 hit_any;
  logic                 tick;
  logic                 mtime_wr;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    req_ready_o = 1'b1;
    rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept = req_valid_i;
        if (req_valid_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        req_ready_o = rsp_ready_i;
        accept      = req_valid_i & rsp_ready_i;
        if (rsp_ready_i && !req_valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address bits [2:0] select a byte within the word and are covered by the strobes.
  assign word             = req_addr_i[AddrWidth-1:3];
  assign unused_addr_lsbs = ^req_addr_i[2:0];
  assign hit_mtime        = (word == MtimeWord);

  always_comb begin
    for (int h = 0; h < NumHarts; h++) begin
      hit_cmp[h] = (word == CmpWord + WordWidth'(h));
    end
    for (int k = 0; k < PairCount; k++) begin
      hit_pair[k] = (word == WordWidth'(k));
    end
  end

  assign hit_any  = hit_mtime | (|hit_cmp) | (|hit_pair);
  assign mtime_wr = accept & req_we_i & hit_mtime;

`ifdef MUNTJAC_CLINT_PRESCALE_EN
  logic [15:0] presc_q, presc_d;

  assign tick = (presc_q == 16'(TickDiv - 1));

  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (mtime_wr) presc_d = 16'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) presc_q <= '0;
    else       presc_q <= presc_d;
  end
`else
  localparam int unsigned unused_tick_div = TickDiv;
  assign tick = 1'b1;
`endif

  // Reads return pre-edge values; an mtime write replaces this cycle's increment.
  always_comb begin
    mtime_d    = mtime_q + {63'd0, tick};
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    if (accept) begin
      rdata_d = '0;
      error_d = ~hit_any;
      if (hit_mtime) begin
        if (req_we_i) mtime_d = byte_merge(mtime_q, req_wdata_i, req_wmask_i);
        else          rdata_d = mtime_q;
      end
      for (int h = 0; h < NumHarts; h++) begin
        if (hit_cmp[h]) begin
          if (req_we_i) mtimecmp_d[h] = byte_merge(mtimecmp_q[h], req_wdata_i, req_wmask_i);
          else          rdata_d = mtimecmp_q[h];
        end
      end
      // Even harts live in the low 32-bit half of a pair word, odd harts in the high half.
      for (int h = 0; h < NumHarts; h++) begin
        if (hit_pair[h/2]) begin
          if (req_we_i) begin
            if (req_wmask_i[4*(h%2)]) msip_d[h] = req_wdata_i[32*(h%2)];
          end else begin
            rdata_d[32*(h%2)] = msip_q[h];
          end
        end
      end
    end
  end

  always_comb begin
    for (int h = 0; h < NumHarts; h++) begin
      irq_timer_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q     <= '0;
      msip_q      <= '0;
      irq_timer_q <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      for (int h = 0; h < NumHarts; h++) begin
        mtimecmp_q[h] <= '1;
      end
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      irq_timer_q <= irq_timer_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
    end
  end

  assign rsp_rdata_o      = rdata_q;
  assign rsp_error_o      = error_q;
  assign mtime_o          = mtime_q;
  assign irq_software_m_o = msip_q;
  assign irq_timer_m_o    = irq_timer_q;

endmodule

// File: tb/tb_muntjac_clint.sv
// Bench for muntjac_clint: directed steps plus random bus traffic against a transaction-level model.
module tb_muntjac_clint;
  localparam int NH   = 2;
  localparam int TICK = 4;
  localparam int K_ERR = 0, K_MTIME = 1, K_CMP = 2, K_MSIP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [15:0]   req_addr;
  logic [63:0]   req_wdata;
  logic [7:0]    req_wmask;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [63:0]   rsp_rdata, mtime;
  logic [NH-1:0] irq_sw, irq_tm;

  always #5 clk = ~clk;

  muntjac_clint #(.NumHarts(NH), .AddrWidth(16), .TickDiv(TICK)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .mtime_o(mtime),
    .irq_software_m_o(irq_sw), .irq_timer_m_o(irq_tm)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip, m_irq;
  logic          m_pend, m_err;
  logic [63:0]   m_rdata;
`ifdef MUNTJAC_CLINT_PRESCALE_EN
  int            m_presc;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [15:0] addr, output int idx);
    int a;
    a = int'(addr) & ~7;
    idx = 0;
    if (a == 'hBFF8) return K_MTIME;
    if (a >= 'h4000 && a < 'h4000 + 8*NH) begin
      idx = (a - 'h4000) / 8;
      return K_CMP;
    end
    if (a < 8*((NH+1)/2)) begin
      idx = a / 8;
      return K_MSIP;
    end
    return K_ERR;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] m);
    logic [63:0] bm;
    bm = '0;
    for (int b = 0; b < 8; b++) if (m[b]) bm = bm | (64'hFF << (8*b));
    return (old_v & ~bm) | (new_v & bm);
  endfunction

  task automatic model_reset();
    m_mtime = '0;
    for (int h = 0; h < NH; h++) m_cmp[h] = '1;
    m_msip  = '0;
    m_irq   = '0;
    m_pend  = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
`ifdef MUNTJAC_CLINT_PRESCALE_EN
    m_presc = 0;
`endif
  endtask

  // Advance model and DUT by one clock, then compare every observable output.
  task automatic step();
    int            kind, idx;
    logic          acc, tick;
    logic [63:0]   nxt_mtime;
    logic [NH-1:0] nxt_irq;
    acc = req_valid && (!m_pend || rsp_ready);
    if (rst) begin
      model_reset();
    end else begin
`ifdef MUNTJAC_CLINT_PRESCALE_EN
      tick = (m_presc == TICK - 1);
      m_presc = tick ? 0 : m_presc + 1;
`else
      tick = 1'b1;
`endif
      nxt_mtime = m_mtime + 64'(tick);
      for (int h = 0; h < NH; h++) nxt_irq[h] = (m_mtime >= m_cmp[h]);
      if (m_pend && rsp_ready) m_pend = 1'b0;
      if (acc) begin
        kind    = decode(req_addr, idx);
        m_rdata = '0;
        m_err   = (kind == K_ERR);
        case (kind)
          K_MTIME: begin
            if (req_we) begin
              nxt_mtime = merge(m_mtime, req_wdata, req_wmask);
`ifdef MUNTJAC_CLINT_PRESCALE_EN
              m_presc = 0;
`endif
            end else m_rdata = m_mtime;
          end
          K_CMP: begin
            if (req_we) m_cmp[idx] = merge(m_cmp[idx], req_wdata, req_wmask);
            else        m_rdata = m_cmp[idx];
          end
          K_MSIP: begin
            if (req_we) begin
              if (req_wmask[0]) m_msip[2*idx] = req_wdata[0];
              if (2*idx+1 < NH && req_wmask[4]) m_msip[2*idx+1] = req_wdata[32];
            end else begin
              m_rdata[0]  = m_msip[2*idx];
              m_rdata[32] = (2*idx+1 < NH) ? m_msip[2*idx+1] : 1'b0;
            end
          end
          default: ;
        endcase
        m_pend = 1'b1;
      end
      m_mtime = nxt_mtime;
      m_irq   = nxt_irq;
    end
    @(posedge clk);
    #1;
    chk("mtime", mtime, m_mtime);
    chk("irq_timer", 64'(irq_tm), 64'(m_irq));
    chk("irq_software", 64'(irq_sw), 64'(m_msip));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_pend));
    chk("req_ready", 64'(req_ready), 64'(!m_pend || rsp_ready));
    if (m_pend) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_error", 64'(rsp_error), 64'(m_err));
    end
  endtask

  task automatic xact(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                      input logic [7:0] wm, output logic [63:0] rd, output logic er);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wmask = wm;
    rsp_ready = 1'b1;
    step();
    rd = rsp_rdata;
    er = rsp_error;
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    logic [63:0] rd, held, t0;
    logic        er, hit;
    logic [15:0] addrs [8];
    addrs = '{16'h0000, 16'h0008, 16'h4000, 16'h4008, 16'h4010, 16'hBFF8, 16'h8000, 16'h0004};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    model_reset();
    step(); step();
    chk("reset_mtime", mtime, 64'd0);
    chk("reset_rdata", rsp_rdata, 64'd0);
    chk("reset_flags", {60'd0, req_ready, rsp_valid, rsp_error, |irq_tm}, 64'h8);
    rst = 1'b0;
    repeat (10) step();
`ifdef MUNTJAC_CLINT_PRESCALE_EN
    chk("idle10_mtime", mtime, 64'(10 / TICK));
`else
    chk("idle10_mtime", mtime, 64'd10);
`endif

    // Timer interrupt rises the cycle after mtime first equals mtimecmp.
    t0 = m_mtime + 64'd8;
    xact(1'b1, 16'h4000, t0, 8'hFF, rd, er);
    chk("cmp_wr_error", 64'(er), 64'd0);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      if (mtime == t0) hit = 1'b1;
    end
    chk("irq_wait", mtime, t0);
    chk("irq_before", 64'(irq_tm[0]), 64'd0);
    step();
    chk("irq_after", 64'(irq_tm[0]), 64'd1);

    // Software interrupts through both halves of the msip pair.
    xact(1'b1, 16'h0000, 64'd1, 8'h0F, rd, er);
    chk("msip0_set", 64'(irq_sw), 64'd1);
    xact(1'b0, 16'h0000, 64'd0, 8'h00, rd, er);
    chk("msip0_read", rd, 64'd1);
    xact(1'b1, 16'h0000, 64'd0, 8'h0F, rd, er);
    chk("msip0_clr", 64'(irq_sw), 64'd0);
    xact(1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, rd, er);
    xact(1'b0, 16'h0000, 64'd0, 8'h00, rd, er);
    chk("msip1_read", rd, 64'h1_0000_0000);
    xact(1'b1, 16'h0000, 64'd0, 8'hFF, rd, er);

    // mtime wrap with mtimecmp at all-ones.
    xact(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'hBFF8;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFE; req_wmask = 8'hFF;
    step();
    chk("wrap_fe", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    req_valid = 1'b0;
    step();
`ifndef MUNTJAC_CLINT_PRESCALE_EN
    chk("wrap_ff", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("wrap_zero", mtime, 64'd0);
    chk("wrap_irq_hi", 64'(irq_tm[0]), 64'd1);
    step();
    chk("wrap_irq_lo", 64'(irq_tm[0]), 64'd0);
`endif
    repeat (2 * TICK + 2) step();

    // Unmapped addresses.
    xact(1'b0, 16'h8000, 64'd0, 8'h00, rd, er);
    chk("err_rdata", rd, 64'd0);
    chk("err_flag", 64'(er), 64'd1);
    xact(1'b0, 16'h4010, 64'd0, 8'h00, rd, er);
    chk("err_cmp_oob", 64'(er), 64'd1);

    // Back-pressure then back-to-back reads.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hBFF8; rsp_ready = 1'b1;
    step();
    held = rsp_rdata;
    rsp_ready = 1'b0; req_addr = 16'h4000;
    repeat (3) begin
      step();
      chk("stall_hold", rsp_rdata, held);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = addrs[i + 2];
      step();
      chk("b2b_valid", 64'(rsp_valid), 64'd1);
    end
    req_valid = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1);
      req_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 7)];
      req_wmask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      case ($urandom_range(0, 2))
        0:       req_wdata = m_mtime + 64'($urandom_range(0, 12));
        1:       req_wdata = {32'd0, $urandom};
        default: req_wdata = {$urandom, $urandom};
      endcase
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();

    // Reset while a response is outstanding.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4008;
    step();
    rst = 1'b1; req_valid = 1'b0;
    step();
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_mtime", mtime, 64'd0);
    rst = 1'b0;
    repeat (12) step();
`ifdef MUNTJAC_CLINT_PRESCALE_EN
    chk("post12_mtime", mtime, 64'd3);
`else
    chk("post12_mtime", mtime, 64'd12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
